lcd_frame_writer: RTL



---
 rtl/lcd_pkg.sv | 46 ++++
 rtl/lcd_byte_strobe.sv | 96 +++++++++
 rtl/lcd_frame_writer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, HD44780 command bytes and timing defaults
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_INIT,
      ST_LATCH,
      ST_ADDR0,
      ST_CHAR0,
      ST_ADDR1,
      ST_CHAR1
   } lcd_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_STROBE,
      PH_HOLD
   } lcd_phase_e;

   localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;
   localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
   localparam logic [7:0] LCD_CLEAR        = 8'h01;
   localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;
   localparam logic [7:0] LCD_LINE0_ADDR   = 8'h80;
   localparam logic [7:0] LCD_LINE1_ADDR   = 8'hC0;

   localparam int DEF_INIT_WAIT  = 750000;
   localparam int DEF_EN_HIGH    = 12;
   localparam int DEF_CMD_WAIT   = 2500;
   localparam int DEF_CLEAR_WAIT = 82000;

   localparam int WAIT_W   = 20;
   localparam int INIT_LEN = 5;

   // Power-up command list; the function set is sent twice as the controller expects
   function automatic logic [7:0] init_cmd(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd1: init_cmd = LCD_FUNC_8BIT_2L;
         4'd2:       init_cmd = LCD_DISP_ON;
         4'd3:       init_cmd = LCD_CLEAR;
         default:    init_cmd = LCD_ENTRY_INC;
      endcase
   endfunction

endpackage

// File: rtl/lcd_byte_strobe.sv
// rtl/lcd_byte_strobe.sv - one LCD write: setup, enable strobe, post-write hold
module lcd_byte_strobe
   import lcd_pkg::*;
#(
   parameter int EN_HIGH    = DEF_EN_HIGH,
   parameter int CMD_WAIT   = DEF_CMD_WAIT,
   parameter int CLEAR_WAIT = DEF_CLEAR_WAIT
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [7:0]        data_byte,
   input  logic              rs,
   input  logic              long_wait,
   input  logic [WAIT_W-1:0] cnt,
   output logic              cnt_restart,
   output logic [7:0]        lcd_data,
   output logic              lcd_rs,
   output logic              lcd_en,
   output logic              ready
);

   lcd_phase_e        phase_q, phase_d;
   logic [7:0]        data_q, data_d;
   logic              rs_q, rs_d;
   logic              en_q, en_d;
   logic              long_q, long_d;
   logic [WAIT_W-1:0] hold_len;
   logic              strobe_last;
   logic              hold_last;

   always_ff @(posedge clk) begin
      if (clr) begin
         phase_q <= PH_IDLE;
         data_q  <= 8'h00;
         rs_q    <= 1'b0;
         en_q    <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         en_q    <= en_d;
         long_q  <= long_d;
      end
   end

   // ready marks the last cycle of a byte so the next one can follow back-to-back
   always_comb begin
      hold_len    = long_q ? WAIT_W'(CLEAR_WAIT) : WAIT_W'(CMD_WAIT);
      strobe_last = (cnt == WAIT_W'(EN_HIGH - 1));
      hold_last   = (cnt == hold_len - 20'd1);
      case (phase_q)
         PH_IDLE:   ready = 1'b1;
         PH_STROBE: ready = strobe_last && (hold_len == '0);
         PH_HOLD:   ready = hold_last;
         default:   ready = 1'b0;
      endcase
   end

   always_comb begin
      phase_d     = phase_q;
      data_d      = data_q;
      rs_d        = rs_q;
      long_d      = long_q;
      cnt_restart = 1'b0;
      case (phase_q)
         PH_SETUP: begin
            phase_d     = PH_STROBE;
            cnt_restart = 1'b1;
         end
         PH_STROBE: if (strobe_last) begin
            phase_d     = (hold_len == '0) ? PH_IDLE : PH_HOLD;
            cnt_restart = 1'b1;
         end
         PH_HOLD: if (hold_last) begin
            phase_d     = PH_IDLE;
            cnt_restart = 1'b1;
         end
         default: ;
      endcase
      if (ready && start) begin
         phase_d     = PH_SETUP;
         data_d      = data_byte;
         rs_d        = rs;
         long_d      = long_wait;
         cnt_restart = 1'b1;
      end
      en_d = (phase_d == PH_STROBE);
   end

   assign lcd_data = data_q;
   assign lcd_rs   = rs_q;
   assign lcd_en   = en_q;

endmodule

// File: rtl/lcd_frame_writer.sv
// rtl/lcd_frame_writer.sv - HD44780 init sequence and continuous two-line refresh
module lcd_frame_writer
   import lcd_pkg::*;
#(
   parameter int INIT_WAIT  = DEF_INIT_WAIT,
   parameter int EN_HIGH    = DEF_EN_HIGH,
   parameter int CMD_WAIT   = DEF_CMD_WAIT,
   parameter int CLEAR_WAIT = DEF_CLEAR_WAIT
) (
   input  logic         CLK,
   input  logic         CLR,
   input  logic [127:0] LINE0,
   input  logic [127:0] LINE1,
   output logic [7:0]   LCD_DATA,
   output logic         LCD_RS,
   output logic         LCD_RW,
   output logic         LCD_EN,
   output logic         LCD_ON,
   output logic         init_done,
   output logic         frame_done
);

   lcd_state_e        state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [127:0]      line0_q, line0_d;
   logic [127:0]      line1_q, line1_d;
   logic              init_done_q, init_done_d;
   logic              lcd_on_q;
   logic              adv;
   logic              start;
   logic [7:0]        tx_byte;
   logic              tx_rs;
   logic              tx_long;
   logic              cnt_restart;
   logic              ready;

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q     <= ST_PWR_WAIT;
         idx_q       <= 4'd0;
         cnt_q       <= '0;
         line0_q     <= '0;
         line1_q     <= '0;
         init_done_q <= 1'b0;
         lcd_on_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         line0_q     <= line0_d;
         line1_q     <= line1_d;
         init_done_q <= init_done_d;
         lcd_on_q    <= 1'b1;
      end
   end

   // Every advance into a sending state coincides with a start, so inside those
   // states the strobe's ready can only mean the current byte is finishing.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      line0_d     = line0_q;
      line1_d     = line1_q;
      init_done_d = init_done_q;
      adv         = 1'b0;
      case (state_q)
         ST_PWR_WAIT: if (cnt_q == WAIT_W'(INIT_WAIT)) begin
            adv     = 1'b1;
            state_d = ST_INIT;
            idx_d   = 4'd0;
         end
         ST_INIT: if (ready) begin
            adv = 1'b1;
            if (idx_q == 4'(INIT_LEN - 1)) begin
               state_d     = ST_LATCH;
               idx_d       = 4'd0;
               init_done_d = 1'b1;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         ST_LATCH: begin
            adv     = 1'b1;
            state_d = ST_ADDR0;
            line0_d = LINE0;
            line1_d = LINE1;
         end
         ST_ADDR0: if (ready) begin
            adv     = 1'b1;
            state_d = ST_CHAR0;
            idx_d   = 4'd0;
         end
         ST_CHAR0: if (ready) begin
            adv   = 1'b1;
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) state_d = ST_ADDR1;
         end
         ST_ADDR1: if (ready) begin
            adv     = 1'b1;
            state_d = ST_CHAR1;
            idx_d   = 4'd0;
         end
         ST_CHAR1: if (ready) begin
            adv   = 1'b1;
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) state_d = ST_LATCH;
         end
         default: state_d = ST_PWR_WAIT;
      endcase
      cnt_d = cnt_restart ? '0 : cnt_q + 20'd1;
   end

   // The byte handed to the strobe is the one for the position being entered
   always_comb begin
      start   = adv && (state_d != ST_LATCH);
      tx_byte = 8'h00;
      tx_rs   = 1'b0;
      case (state_d)
         ST_INIT:  tx_byte = init_cmd(idx_d);
         ST_ADDR0: tx_byte = LCD_LINE0_ADDR;
         ST_CHAR0: begin
            tx_byte = line0_q[{~idx_d, 3'b000} +: 8];
            tx_rs   = 1'b1;
         end
         ST_ADDR1: tx_byte = LCD_LINE1_ADDR;
         ST_CHAR1: begin
            tx_byte = line1_q[{~idx_d, 3'b000} +: 8];
            tx_rs   = 1'b1;
         end
         default: ;
      endcase
      tx_long    = (state_d == ST_INIT) && (tx_byte == LCD_CLEAR);
      frame_done = (state_q == ST_CHAR1) && (idx_q == 4'd15) && ready;
   end

   lcd_byte_strobe #(
      .EN_HIGH    (EN_HIGH),
      .CMD_WAIT   (CMD_WAIT),
      .CLEAR_WAIT (CLEAR_WAIT)
   ) u_strobe (
      .clk         (CLK),
      .clr         (CLR),
      .start       (start),
      .data_byte   (tx_byte),
      .rs          (tx_rs),
      .long_wait   (tx_long),
      .cnt         (cnt_q),
      .cnt_restart (cnt_restart),
      .lcd_data    (LCD_DATA),
      .lcd_rs      (LCD_RS),
      .lcd_en      (LCD_EN),
      .ready       (ready)
   );

   assign LCD_RW    = 1'b0;
   assign LCD_ON    = lcd_on_q;
   assign init_done = init_done_q;

endmodule
